// File: rtl/quad_enc_pkg.sv
// Shared definitions for the quadrature encoder front end: mode encodings and
// the A/B transition lookup used by the decoder.
package quad_enc_pkg;

  localparam logic [1:0] MODE_X4 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X1 = 2'd2;

  typedef struct packed {
    logic legal;
    logic step;
    logic sign;  // 1 = forward
  } trans_t;

  // Position of {A,B} within the forward cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] phase_idx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  function automatic trans_t decode_trans(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] d;
    trans_t     t;
    d       = phase_idx(cur_ab) - phase_idx(prev_ab);
    t.legal = (d != 2'd2);
    t.step  = (d == 2'd1) || (d == 2'd3);
    t.sign  = (d == 2'd1);
    return t;
  endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// Synchroniser plus stable-count glitch filter for one encoder input. The
// filtered value is loaded directly from the first fully synchronised sample.
module enc_glitch_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic [FILT_W-1:0] filt_len,
  output logic              dout,
  output logic              valid
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic [FILT_W-1:0]      cnt_q;
  logic                   filt_q;
  logic                   valid_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      if (!valid_q) begin
        cnt_q <= '0;
        if (fill_q[SYNC_STAGES-1]) begin
          filt_q  <= synced;
          valid_q <= 1'b1;
        end
      end else if (synced == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= filt_len) begin
        // >= so a shortened filt_len mid-count cannot strand the counter.
        filt_q <= synced;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + FILT_W'(1);
      end
    end
  end

  assign dout  = filt_q;
  assign valid = valid_q;

endmodule

// File: rtl/quad_enc_decoder.sv
// Quadrature encoder front end: filtered A/B/Z, x1/x2/x4 position decode,
// edge and error counters, index latch and per-step pulse.
module quad_enc_decoder
  import quad_enc_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_a,
  input  logic              enc_b,
  input  logic              enc_z,
  input  logic              cfg_swap_ab,
  input  logic              cfg_dir_inv,
  input  logic [1:0]        cfg_mode,
  input  logic [FILT_W-1:0] cfg_filt_len,
  input  logic              cfg_z_clr_en,
  input  logic              cfg_clr,
  output logic [CNT_W-1:0]  position,
  output logic [CNT_W-1:0]  a_edge_cnt,
  output logic [CNT_W-1:0]  b_edge_cnt,
  output logic [15:0]       err_cnt,
  output logic [CNT_W-1:0]  z_pos,
  output logic              z_valid,
  output logic              step_pulse,
  output logic              step_dir,
  output logic              dir
);

  logic a_f, b_f, z_f, a_v, b_v, z_v;

  enc_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filt_a (
    .clk(clk), .rst(rst), .din(enc_a), .filt_len(cfg_filt_len), .dout(a_f), .valid(a_v)
  );
  enc_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filt_b (
    .clk(clk), .rst(rst), .din(enc_b), .filt_len(cfg_filt_len), .dout(b_f), .valid(b_v)
  );
  enc_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filt_z (
    .clk(clk), .rst(rst), .din(enc_z), .filt_len(cfg_filt_len), .dout(z_f), .valid(z_v)
  );

  logic             armed_q, armed_d;
  logic             prev_a_q, prev_b_q, prev_z_q;
  logic [CNT_W-1:0] pos_q, pos_d, a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d, z_pos_q, z_pos_d;
  logic [15:0]      err_q, err_d;
  logic             z_valid_q, z_valid_d, step_q, step_d, step_dir_q, step_dir_d, dir_q, dir_d;

  logic [1:0] cur_ab, prev_ab;
  trans_t     tr;
  logic       gate, step, up, illegal, z_rise, a_rise, b_rise;

  always_comb begin
    // Prev is kept in physical order and swapped here, so toggling the swap
    // while idle never looks like a transition.
    cur_ab  = cfg_swap_ab ? {b_f, a_f} : {a_f, b_f};
    prev_ab = cfg_swap_ab ? {prev_b_q, prev_a_q} : {prev_a_q, prev_b_q};
    tr      = decode_trans(prev_ab, cur_ab);
    case (cfg_mode)
      MODE_X2: gate = cur_ab[1] ^ prev_ab[1];
      MODE_X1: gate = (cur_ab[1] ^ prev_ab[1]) & (cur_ab[1] == tr.sign);
      default: gate = 1'b1;
    endcase
    step    = armed_q & tr.step & gate;
    up      = tr.sign ^ cfg_dir_inv;
    illegal = armed_q & ~tr.legal;
    z_rise  = armed_q & z_f & ~prev_z_q;
    a_rise  = armed_q & a_f & ~prev_a_q;
    b_rise  = armed_q & b_f & ~prev_b_q;

    armed_d    = armed_q | (a_v & b_v & z_v);
    pos_d      = pos_q;
    a_cnt_d    = a_cnt_q;
    b_cnt_d    = b_cnt_q;
    err_d      = err_q;
    z_pos_d    = z_pos_q;
    z_valid_d  = 1'b0;
    step_d     = 1'b0;
    step_dir_d = step_dir_q;
    dir_d      = dir_q;

    if (cfg_clr) begin
      pos_d   = '0;
      a_cnt_d = '0;
      b_cnt_d = '0;
      err_d   = '0;
      z_pos_d = '0;
    end else begin
      if (step) begin
        pos_d      = up ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
        step_d     = 1'b1;
        step_dir_d = up;
        dir_d      = up;
      end
      if (z_rise) begin
        z_pos_d   = pos_q;
        z_valid_d = 1'b1;
        if (cfg_z_clr_en) pos_d = '0;
      end
      if (a_rise) a_cnt_d = a_cnt_q + CNT_W'(1);
      if (b_rise) b_cnt_d = b_cnt_q + CNT_W'(1);
      if (illegal && err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b0;
      prev_a_q   <= 1'b0;
      prev_b_q   <= 1'b0;
      prev_z_q   <= 1'b0;
      pos_q      <= '0;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      err_q      <= '0;
      z_pos_q    <= '0;
      z_valid_q  <= 1'b0;
      step_q     <= 1'b0;
      step_dir_q <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      prev_a_q   <= a_f;
      prev_b_q   <= b_f;
      prev_z_q   <= z_f;
      pos_q      <= pos_d;
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      err_q      <= err_d;
      z_pos_q    <= z_pos_d;
      z_valid_q  <= z_valid_d;
      step_q     <= step_d;
      step_dir_q <= step_dir_d;
      dir_q      <= dir_d;
    end
  end

  assign position   = pos_q;
  assign a_edge_cnt = a_cnt_q;
  assign b_edge_cnt = b_cnt_q;
  assign err_cnt    = err_q;
  assign z_pos      = z_pos_q;
  assign z_valid    = z_valid_q;
  assign step_pulse = step_q;
  assign step_dir   = step_dir_q;
  assign dir        = dir_q;

endmodule

// File: tb/tb_quad_enc_decoder.sv
// Randomised scoreboard bench for quad_enc_decoder: a pin-level reference model
// queues expected steps and index latches; a monitor checks them as they appear.
module tb_quad_enc_decoder;

  localparam int CNT_W = 32;
  localparam int SYNC  = 2;
  localparam int FILT_W = 8;

  logic              clk, rst, enc_a, enc_b, enc_z;
  logic              cfg_swap_ab, cfg_dir_inv, cfg_z_clr_en, cfg_clr;
  logic [1:0]        cfg_mode;
  logic [FILT_W-1:0] cfg_filt_len;
  logic [CNT_W-1:0]  position, a_edge_cnt, b_edge_cnt, z_pos;
  logic [15:0]       err_cnt;
  logic              z_valid, step_pulse, step_dir, dir;

  quad_enc_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .FILT_W(FILT_W)) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .cfg_swap_ab(cfg_swap_ab), .cfg_dir_inv(cfg_dir_inv), .cfg_mode(cfg_mode),
    .cfg_filt_len(cfg_filt_len), .cfg_z_clr_en(cfg_z_clr_en), .cfg_clr(cfg_clr),
    .position(position), .a_edge_cnt(a_edge_cnt), .b_edge_cnt(b_edge_cnt),
    .err_cnt(err_cnt), .z_pos(z_pos), .z_valid(z_valid), .step_pulse(step_pulse),
    .step_dir(step_dir), .dir(dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int npulse = 0;

  logic [32:0] step_q[$];
  logic [31:0] zq[$];
  logic [32:0] exp_s;
  logic [31:0] exp_z;

  // Reference model state (pins are physical {A,B}).
  logic [31:0] m_pos, m_a_cnt, m_b_cnt, m_zpos;
  logic [15:0] m_err;
  logic        m_dir, m_z;
  logic [1:0]  m_ab;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] phase_at(input int i);
    logic [1:0] seq[4];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    return seq[i % 4];
  endfunction

  function automatic int idx_of(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (phase_at(i) == ab) return i;
    return 0;
  endfunction

  function automatic logic [1:0] sw(input logic [1:0] ab);
    return cfg_swap_ab ? {ab[0], ab[1]} : ab;
  endfunction

  // Physical pins for one phase step forward (+1) or reverse (-1) in decoded space.
  function automatic logic [1:0] phase_step(input int delta);
    return sw(phase_at(idx_of(sw(m_ab)) + delta + 4));
  endfunction

  task automatic model_reset();
    m_pos = 0; m_a_cnt = 0; m_b_cnt = 0; m_zpos = 0; m_err = 0;
  endtask

  task automatic model_update(input logic [1:0] ab_new, input logic z_new);
    logic [1:0] p, c;
    int d;
    bit fwd, cnt, zero, up;
    p = sw(m_ab);
    c = sw(ab_new);
    if (ab_new[1] && !m_ab[1]) m_a_cnt++;
    if (ab_new[0] && !m_ab[0]) m_b_cnt++;
    zero = 0;
    if (z_new && !m_z) begin
      zq.push_back(m_pos);
      m_zpos = m_pos;
      zero = cfg_z_clr_en;
    end
    if (p != c) begin
      d = (idx_of(c) - idx_of(p) + 4) % 4;
      if (d == 2) begin
        if (m_err != 16'hFFFF) m_err++;
      end else begin
        fwd = (d == 1);
        if (cfg_mode == 2'd1) cnt = (c[1] != p[1]);
        else if (cfg_mode == 2'd2) cnt = (c[1] != p[1]) && (c[1] == fwd);
        else cnt = 1;
        if (cnt) begin
          up = fwd ^ cfg_dir_inv;
          if (zero) m_pos = 0;
          else if (up) m_pos = m_pos + 1;
          else m_pos = m_pos - 1;
          m_dir = up;
          step_q.push_back({up, m_pos});
          zero = 0;
        end
      end
    end
    if (zero) m_pos = 0;
    m_ab = ab_new;
    m_z = z_new;
  endtask

  task automatic move(input logic [1:0] ab, input logic z, input int hold);
    model_update(ab, z);
    {enc_a, enc_b} = ab;
    enc_z = z;
    tick(hold);
  endtask

  task automatic do_clr();
    cfg_clr = 1'b1;
    tick(1);
    cfg_clr = 1'b0;
    model_reset();
  endtask

  task automatic checkpoint(input string tag);
    tick(SYNC + int'(cfg_filt_len) + 4);
    check({tag, " position"}, position, m_pos);
    check({tag, " a_edge"}, a_edge_cnt, m_a_cnt);
    check({tag, " b_edge"}, b_edge_cnt, m_b_cnt);
    check({tag, " err"}, err_cnt, m_err);
    check({tag, " z_pos"}, z_pos, m_zpos);
    check({tag, " dir"}, dir, m_dir);
    check({tag, " pending steps"}, step_q.size(), 0);
    check({tag, " pending z"}, zq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (step_pulse) begin
        npulse++;
        total++;
        if (step_q.size() == 0) begin
          bad++;
          $display("FAIL step: unexpected pulse got pos=%0h expected none", position);
        end else begin
          exp_s = step_q.pop_front();
          if ({step_dir, position} !== exp_s) begin
            bad++;
            $display("FAIL step: got dir=%0b pos=%0h expected dir=%0b pos=%0h",
                     step_dir, position, exp_s[32], exp_s[31:0]);
          end
        end
      end
      if (z_valid) begin
        total++;
        if (zq.size() == 0) begin
          bad++;
          $display("FAIL z_valid: unexpected pulse got z_pos=%0h expected none", z_pos);
        end else begin
          exp_z = zq.pop_front();
          if (z_pos !== exp_z) begin
            bad++;
            $display("FAIL z_pos: got %0h expected %0h", z_pos, exp_z);
          end
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, lat, zv, hold;
    logic [1:0] ab;
    rst = 1'b1; enc_a = 0; enc_b = 0; enc_z = 0;
    cfg_swap_ab = 0; cfg_dir_inv = 0; cfg_mode = 2'd0; cfg_filt_len = '0;
    cfg_z_clr_en = 0; cfg_clr = 0;
    m_ab = 2'b00; m_z = 0; m_dir = 0;
    model_reset();
    tick(3);
    check("reset position", position, 0);
    check("reset err", err_cnt, 0);
    check("reset a_edge", a_edge_cnt, 0);
    check("reset step_pulse", step_pulse, 0);
    check("reset z_valid", z_valid, 0);
    rst = 1'b0;
    tick(8);

    // x4: 4 forward cycles then 2 reverse cycles.
    n0 = npulse;
    repeat (16) move(phase_step(1), m_z, 2);
    repeat (8) move(phase_step(-1), m_z, 2);
    checkpoint("x4");
    check("x4 position", position, 8);
    check("x4 pulses", npulse - n0, 24);
    check("x4 dir", dir, 0);

    do_clr();
    cfg_mode = 2'd1;
    repeat (16) move(phase_step(1), m_z, 2);
    checkpoint("x2");
    check("x2 position", position, 8);
    do_clr();
    cfg_mode = 2'd2;
    repeat (16) move(phase_step(1), m_z, 2);
    checkpoint("x1");
    check("x1 position", position, 4);
    do_clr();
    cfg_mode = 2'd0; cfg_dir_inv = 1;
    repeat (16) move(phase_step(1), m_z, 2);
    checkpoint("inv");
    check("inv position", position, 32'hFFFF_FFF0);
    cfg_dir_inv = 0;

    // Latency and glitch rejection with filt_len = 5.
    cfg_filt_len = 8'd5;
    tick(2);
    ab = phase_step(1);
    model_update(ab, m_z);
    {enc_a, enc_b} = ab;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (step_pulse) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, SYNC + 7);
    tick(4);
    enc_a = ~enc_a;
    tick(3);
    enc_a = m_ab[1];
    checkpoint("glitch");

    // Randomised motion, glitches, index and config changes.
    for (int l = 0; l < 2; l++) begin
      cfg_filt_len = (l == 0) ? 8'd0 : 8'd3;
      hold = SYNC + int'(cfg_filt_len) + 3;
      tick(2);
      for (int i = 0; i < 120; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: move(phase_step(1), m_z, hold);
          4, 5: move(phase_step(-1), m_z, hold);
          6: move(m_ab ^ 2'b11, m_z, hold);
          7: begin
            if (cfg_filt_len != 0) begin
              case ($urandom_range(0, 2))
                0: enc_a = ~enc_a;
                1: enc_b = ~enc_b;
                default: enc_z = ~enc_z;
              endcase
              tick($urandom_range(1, int'(cfg_filt_len)));
              {enc_a, enc_b} = m_ab;
              enc_z = m_z;
              tick(hold);
            end else begin
              move(m_ab, ~m_z, hold);
            end
          end
          8: move(m_ab, ~m_z, hold);
          default: begin
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_swap_ab = 1'($urandom_range(0, 1));
            cfg_dir_inv = 1'($urandom_range(0, 1));
            cfg_z_clr_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) do_clr();
            tick(1);
          end
        endcase
      end
      checkpoint("random");
    end

    // Single illegal transition.
    cfg_filt_len = '0; cfg_mode = 2'd0; cfg_swap_ab = 0; cfg_dir_inv = 0; cfg_z_clr_en = 0;
    if (m_z) move(m_ab, 1'b0, 4);
    tick(2);
    do_clr();
    move(m_ab ^ 2'b11, m_z, 2);
    checkpoint("illegal");
    check("illegal err", err_cnt, 1);
    check("illegal position", position, 0);

    // Index latch coincident with a forward step, clear-on-Z enabled.
    do_clr();
    repeat (1234) move(phase_step(1), m_z, 1);
    checkpoint("ramp");
    check("ramp position", position, 1234);
    cfg_z_clr_en = 1;
    tick(1);
    move(phase_step(1), 1'b1, 1);
    zv = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (z_valid) zv++;
    end
    check("z pulses", zv, 1);
    check("z_pos latched", z_pos, 1234);
    check("z cleared position", position, 0);
    move(phase_step(-1), m_z, 2);
    checkpoint("wrap");
    check("wrap position", position, 32'hFFFF_FFFF);
    cfg_z_clr_en = 0;

    // Clear coincident with a step: the step is swallowed.
    tick(2);
    n0 = npulse;
    ab = phase_step(1);
    {enc_a, enc_b} = ab;
    tick(SYNC + 1);
    cfg_clr = 1'b1;
    tick(1);
    cfg_clr = 1'b0;
    model_reset();
    m_ab = ab;
    checkpoint("clr");
    check("clr no pulse", npulse - n0, 0);
    check("clr position", position, 0);

    // Asynchronous reset mid-rotation, inputs held at 11.
    {enc_a, enc_b} = phase_step(1);
    tick(1);
    #2 rst = 1'b1;
    {enc_a, enc_b} = 2'b11;
    tick(3);
    check("rst position", position, 0);
    check("rst dir", dir, 0);
    model_reset();
    m_ab = 2'b11; m_dir = 0;
    n0 = npulse;
    rst = 1'b0;
    tick(12);
    checkpoint("reinit");
    check("reinit no pulse", npulse - n0, 0);

    // Error counter saturation.
    do_clr();
    repeat (70000) move(m_ab ^ 2'b11, m_z, 1);
    checkpoint("sat");
    check("sat err", err_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
